mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `SequentialMultiplier` (start/ready, N-bit operands, 2N-bit product) between NREQ requesters. It sits between the requesters and the multiplier instance. It grants one request at a time, latches that requester's operands and issues a one-cycle `start`. It then tracks the multiplier's `ready` drop and return, captures the product, and returns it tagged with the requester index. A watchdog recovers the block if the multiplier never completes.

---
 rtl/mult_arbiter.sv | 131 +++++++++++++
 tb/tb_mult_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin front end that time-shares one start/ready sequential multiplier
// between NREQ requesters and returns each product tagged with its owner.
module mult_arbiter #(
    parameter int N    = 4,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int TMO  = 2*N+8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*N-1:0]     a,
    input  logic [NREQ*N-1:0]     b,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [2*N-1:0]        result,
    output logic                  busy,
    output logic                  err,
    output logic                  mul_start,
    output logic [N-1:0]          mul_multiplicand,
    output logic [N-1:0]          mul_multiplier,
    input  logic                  mul_ready,
    input  logic [2*N-1:0]        mul_product
);

    localparam int CW = $clog2(TMO);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state, state_nx;
    logic [IDW-1:0]          ptr, id, win;
    logic                    found, seen_low;
    logic [CW-1:0]           wdog;
    logic [NREQ-1:0][N-1:0]  a_v, b_v;
    logic                    arb, complete, expire;

    assign a_v = a;
    assign b_v = b;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p, input int unsigned k);
        int unsigned s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // first set request at or after ptr, searching upward with wrap
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[wrap_inc(ptr, k)]) begin
                found = 1'b1;
                win   = wrap_inc(ptr, k);
            end
        end
    end

    // a ready seen before any low cycle belongs to the previous operation
    assign arb      = mul_ready && found;
    assign complete = mul_ready && seen_low;
    assign expire   = (wdog == CW'(TMO-1));

    always_comb begin
        state_nx  = state;
        gnt       = '0;
        mul_start = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (arb) state_nx = ISSUE;
            ISSUE: begin
                gnt[id]   = 1'b1;
                mul_start = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (complete)    state_nx = DONE;
                else if (expire) state_nx = IDLE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            ptr              <= '0;
            id               <= '0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            result           <= '0;
            done_id          <= '0;
            seen_low         <= 1'b0;
            wdog             <= '0;
            err              <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= 1'b0;
            case (state)
                IDLE: if (arb) begin
                    id               <= win;
                    ptr              <= wrap_inc(win, 1);
                    mul_multiplicand <= a_v[win];
                    mul_multiplier   <= b_v[win];
                end
                ISSUE: begin
                    seen_low <= 1'b0;
                    wdog     <= '0;
                end
                WAIT: begin
                    if (!mul_ready) seen_low <= 1'b1;
                    wdog <= wdog + 1'b1;
                    if (complete) begin
                        result  <= mul_product;
                        done_id <= id;
                    end else if (expire) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomised and directed bench for mult_arbiter with a behavioural multiplier
// and a transaction-level scoreboard checking grants, products and timing.
module tb_mult_arbiter;
    localparam int N = 4, NREQ = 4, IDW = 2, TMO = 2*N+8;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*N-1:0]   a = '0, b = '0;
    logic [NREQ-1:0]     gnt;
    logic                done, busy, err, mul_start, mul_ready;
    logic [IDW-1:0]      done_id;
    logic [2*N-1:0]      result, mul_product;
    logic [N-1:0]        mul_multiplicand, mul_multiplier;

    mult_arbiter #(.N(N), .NREQ(NREQ), .TMO(TMO)) dut (
        .clock(clock), .reset(reset), .req(req), .a(a), .b(b), .gnt(gnt),
        .done(done), .done_id(done_id), .result(result), .busy(busy), .err(err),
        .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_ready(mul_ready), .mul_product(mul_product));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // multiplier: ready low for 2N+1 cycles after start; hang keeps it low
    bit hang = 0;
    int mcnt;
    logic [N-1:0] pa, pb;
    always @(posedge clock) begin
        if (!reset) begin
            mul_ready <= 1'b1; mcnt <= 0; mul_product <= '0;
        end else if (mul_start && mul_ready) begin
            mul_ready <= 1'b0; mcnt <= 2*N+1; mul_product <= '0;
            pa <= mul_multiplicand; pb <= mul_multiplier;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (!mul_ready && !hang) begin
            mcnt <= 0; mul_ready <= 1'b1;
            mul_product <= {{N{1'b0}}, pa} * {{N{1'b0}}, pb};
        end else if (mcnt == 1) begin
            mcnt <= 0;
        end
    end

    int checks = 0, errors = 0;
    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p+k) % NREQ]) return (p+k) % NREQ;
        return -1;
    endfunction

    typedef struct { int id; int prod; int gcyc; bit is_err; } exp_t;
    exp_t sbq[$];
    int gnt_log[$], gnt_cyc[$];
    int mptr = 0, held = 0;
    bit exp_gnt = 0;
    logic [NREQ-1:0]   last_req;
    logic [NREQ*N-1:0] last_a, last_b;

    // monitor: a grant is one acceptance; its product and timing go to the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            sbq.delete(); mptr = 0; exp_gnt = 0; held = 0; last_req = '0;
        end else begin
            int w, eg;
            exp_t e;
            chk((gnt != 0) == exp_gnt, "gnt_timing", int'(gnt != 0), int'(exp_gnt));
            chk(mul_start == (gnt != 0), "start_with_gnt", int'(mul_start), int'(gnt != 0));
            chk(!(done && err), "done_err_exclusive", int'({done, err}), 0);
            if (gnt != 0) begin
                w  = rr(last_req, mptr);
                eg = (w >= 0) ? (1 << w) : 0;
                chk(int'(gnt) == eg, "gnt_winner", int'(gnt), eg);
                if (w >= 0) begin
                    mptr = (w + 1) % NREQ;
                    e.id = w; e.gcyc = cyc; e.is_err = hang;
                    e.prod = int'(last_a[w*N +: N]) * int'(last_b[w*N +: N]);
                    sbq.push_back(e);
                    gnt_log.push_back(w); gnt_cyc.push_back(cyc);
                end
            end
            chk(busy == (sbq.size() > 0 && !err), "busy", int'(busy), int'(sbq.size() > 0 && !err));
            if (done || err) begin
                if (sbq.size() == 0) chk(0, "unexpected_completion", int'({done, err}), 0);
                else begin
                    e = sbq.pop_front();
                    chk(err == e.is_err, "err_vs_done", int'(err), int'(e.is_err));
                    if (e.is_err) chk(cyc == e.gcyc + 1 + TMO, "err_cycle", cyc - e.gcyc, 1 + TMO);
                    else begin
                        chk(cyc == e.gcyc + 2*N + 3, "done_cycle", cyc - e.gcyc, 2*N + 3);
                        chk(int'(done_id) == e.id, "done_id", int'(done_id), e.id);
                        chk(int'(result) == e.prod, "result", int'(result), e.prod);
                        held = e.prod;
                    end
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].gcyc + TMO + 4) begin
                chk(0, "completion_timeout", cyc - sbq[0].gcyc, TMO);
                void'(sbq.pop_front());
            end
            chk(int'(result) == held, "result_held", int'(result), held);
            exp_gnt  = !busy && (req != 0) && mul_ready;
            last_req = req; last_a = a; last_b = b;
        end
    end

    bit auto_drop = 1;
    task automatic tick();
        @(posedge clock); #1;
        if (auto_drop)
            for (int i = 0; i < NREQ; i++) if (gnt[i]) req[i] = 1'b0;
    endtask

    task automatic set_op(input int i, input int x, input int y);
        a[i*N +: N] = N'(x);
        b[i*N +: N] = N'(y);
    endtask

    task automatic check_zero(input string nm);
        logic [25:0] v;
        v = {gnt, done, done_id, result, busy, err, mul_start, mul_multiplicand, mul_multiplier};
        chk(v == 0, nm, int'(v), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        check_zero("reset_outputs");
        reset = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(req == 0 && !busy && sbq.size() == 0) && n < budget) begin tick(); n++; end
        chk(n < budget, "drain_timeout", n, budget);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        repeat (3) tick();
        check_zero("reset_outputs");
        reset = 1'b1;
        tick();

        // single request: 13*11
        set_op(0, 13, 11); req = 4'b0001;
        drain(100);
        chk(int'(result) == 143, "single_result", int'(result), 143);

        // round robin with all requests held
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 15);
        gnt_log.delete(); gnt_cyc.delete();
        auto_drop = 0; req = 4'b1111; n = 0;
        while (gnt_log.size() < 5 && n < 200) begin tick(); n++; end
        req = '0; auto_drop = 1;
        drain(100);
        chk(gnt_log.size() == 5, "rr_count", gnt_log.size(), 5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++)
            chk(gnt_log[k] == k % NREQ, "rr_order", gnt_log[k], k % NREQ);
        for (int k = 1; k < gnt_cyc.size(); k++)
            chk(gnt_cyc[k] - gnt_cyc[k-1] == 2*N + 5, "rr_spacing", gnt_cyc[k] - gnt_cyc[k-1], 2*N + 5);

        // pointer wrap and skip
        do_reset();
        set_op(2, 5, 6); req = 4'b0100;
        drain(100);
        gnt_log.delete();
        set_op(0, 7, 3); set_op(1, 2, 9); req = 4'b0011;
        drain(100);
        chk(gnt_log.size() == 2, "wrap_count", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            chk(gnt_log[0] == 0, "wrap_first", gnt_log[0], 0);
            chk(gnt_log[1] == 1, "wrap_second", gnt_log[1], 1);
        end

        // boundary operands
        set_op(2, 15, 15); req = 4'b0100; drain(100);
        chk(int'(result) == 225, "max_result", int'(result), 225);
        set_op(2, 0, 9);   req = 4'b0100; drain(100);
        chk(int'(result) == 0, "zero_result", int'(result), 0);
        set_op(2, 15, 1);  req = 4'b0100; drain(100);
        chk(int'(result) == 15, "unit_result", int'(result), 15);

        // watchdog: multiplier never completes
        hang = 1;
        set_op(0, 3, 5); req = 4'b0001; n = 0;
        while (!err && n < 100) begin tick(); n++; end
        chk(err == 1'b1, "watchdog_err_seen", int'(err), 1);
        hang = 0;
        tick();
        chk(busy == 1'b0, "watchdog_idle", int'(busy), 0);
        set_op(1, 6, 7); req = 4'b0010;
        drain(100);
        chk(int'(result) == 42, "after_watchdog_result", int'(result), 42);

        // reset during WAIT
        set_op(0, 7, 9); req = 4'b0001; n = 0;
        while (gnt == 0 && n < 50) begin tick(); n++; end
        repeat (3) tick();
        #2 reset = 1'b0;
        #1 check_zero("async_reset_outputs");
        set_op(1, 11, 13); req = 4'b0010;
        repeat (3) tick();
        gnt_log.delete();
        reset = 1'b1;
        drain(100);
        chk(gnt_log.size() == 1 && gnt_log[0] == 1, "post_reset_gnt", gnt_log.size() > 0 ? gnt_log[0] : -1, 1);
        chk(int'(result) == 143, "post_reset_result", int'(result), 143);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && $urandom_range(0, 5) == 0) begin
                    set_op(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                    req[i] = 1'b1;
                end
        end
        drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
